// File: rtl/arbiter_pkg.sv
// Shared types and defaults for the wide adder arbiter and its round-robin picker.
package arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_t;

    localparam int DEFAULT_N_REQ   = 2;
    localparam int DEFAULT_WIDTH   = 514;
    localparam int DEFAULT_TIMEOUT = 1023;

    // Bits needed for a wait counter that must reach the value 'timeout'.
    function automatic int timeout_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    // Bits needed to index one of 'n' requesters (at least one bit).
    function automatic int req_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// Round-robin picker: the winner is the first set request after position ptr,
// wrapping modulo N_REQ, so the last served requester has the lowest priority.
module rr_picker
    import arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int IDX_W = req_idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_winner,
    output logic [IDX_W-1:0] o_winner_idx
);

    // Priority slot gi holds requester (ptr + 1 + gi) mod N_REQ; slot 0 is highest.
    logic [IDX_W-1:0] w_cand_idx [N_REQ];
    logic [N_REQ-1:0] w_cand_req;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
        logic [IDX_W:0] w_sum;
        // ptr <= N_REQ-1 and gi+1 <= N_REQ, so one conditional subtract wraps it.
        assign w_sum = {1'b0, i_ptr} + (IDX_W+1)'(gi + 1);
        assign w_cand_idx[gi] = (w_sum >= (IDX_W+1)'(N_REQ))
                              ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                              : IDX_W'(w_sum);
        assign w_cand_req[gi] = i_req[w_cand_idx[gi]];
    end

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        o_winner     = '0;
        o_winner_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_cand_req[k]) begin
                o_winner                 = '0;
                o_winner[w_cand_idx[k]]  = 1'b1;
                o_winner_idx             = w_cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one multi-cycle wide adder/subtractor between N_REQ requesters.
// Round-robin grant, operand latch, one-cycle start, wait for done (with a
// timeout), then a one-cycle done pulse back to the winner.
module adder_arbiter
    import arbiter_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_sub,
    input  logic [N_REQ-1:0]       req_shift,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH:0]         result,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   adder_start,
    output logic                   adder_sub,
    output logic                   adder_shift,
    output logic [WIDTH-1:0]       adder_a,
    output logic [WIDTH-1:0]       adder_b,
    input  logic [WIDTH:0]         adder_result,
    input  logic                   adder_done
);

    localparam int IDX_W = req_idx_width(N_REQ);
    localparam int CNT_W = timeout_cnt_width(TIMEOUT);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_gidx;
    logic [N_REQ-1:0] r_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_result;
    logic             r_timeout_err;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_shift;

    logic [N_REQ-1:0] w_winner;
    logic [IDX_W-1:0] w_winner_idx;
    logic             w_take;
    logic             w_start;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_capture;
    logic             w_timeout;
    logic             w_respond;

    logic [WIDTH-1:0] w_req_a [N_REQ];
    logic [WIDTH-1:0] w_req_b [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_req_a[gi] = req_a[gi*WIDTH +: WIDTH];
        assign w_req_b[gi] = req_b[gi*WIDTH +: WIDTH];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req        (req),
        .i_ptr        (r_ptr),
        .o_winner     (w_winner),
        .o_winner_idx (w_winner_idx)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_start      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_respond    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_take       = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_start      = 1'b1;
                w_cnt_clr    = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (adder_done) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESPOND;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESPOND;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_RESPOND: begin
                w_respond    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Grant/pointer bookkeeping, operand latch, wait counter and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= IDX_W'(N_REQ - 1);
            r_gidx        <= '0;
            r_grant       <= '0;
            r_cnt         <= '0;
            r_result      <= '0;
            r_timeout_err <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_sub         <= 1'b0;
            r_shift       <= 1'b0;
        end else begin
            if (w_take) begin
                r_grant <= w_winner;
                r_gidx  <= w_winner_idx;
                r_a     <= w_req_a[w_winner_idx];
                r_b     <= w_req_b[w_winner_idx];
                r_sub   <= req_sub[w_winner_idx];
                r_shift <= req_shift[w_winner_idx];
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_result <= adder_result;
            end else if (w_timeout) begin
                r_result      <= '0;
                r_timeout_err <= 1'b1;
            end
            if (w_respond) begin
                r_grant <= '0;
                r_ptr   <= r_gidx;
            end
        end
    end

    assign grant       = r_grant;
    assign done        = w_respond ? r_grant : '0;
    assign busy        = (r_state != ST_IDLE);
    assign adder_start = w_start;
    assign result      = r_result;
    assign timeout_err = r_timeout_err;
    assign adder_a     = r_a;
    assign adder_b     = r_b;
    assign adder_sub   = r_sub;
    assign adder_shift = r_shift;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus randomized request batches,
// a behavioural adder with operand-dependent latency, and a scoreboard monitor
// that predicts grant order, timing and results from the round-robin rules.
module tb_adder_arbiter;

    localparam int N  = 3;
    localparam int W  = 64;
    localparam int TO = 20;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req;
    logic [N-1:0]     req_sub;
    logic [N-1:0]     req_shift;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [W:0]       result;
    logic             busy;
    logic             timeout_err;
    logic             adder_start;
    logic             adder_sub;
    logic             adder_shift;
    logic [W-1:0]     adder_a;
    logic [W-1:0]     adder_b;
    logic [W:0]       adder_result;
    logic             adder_done;

    adder_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_sub      (req_sub),
        .req_shift    (req_shift),
        .req_a        (req_a),
        .req_b        (req_b),
        .grant        (grant),
        .done         (done),
        .result       (result),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .adder_start  (adder_start),
        .adder_sub    (adder_sub),
        .adder_shift  (adder_shift),
        .adder_a      (adder_a),
        .adder_b      (adder_b),
        .adder_result (adder_result),
        .adder_done   (adder_done)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         shift;
        logic [W:0]   res;
        int           lat;
        bit           hang;
    } exp_t;

    exp_t exp_q [N][$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   adder_hang = 0;
    int   spur_req = 0;
    int   reps [N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Adder behaviour: shift doubles A, otherwise A+B or A-B with carry/borrow on top.
    function automatic logic [W:0] op_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub, input logic shift);
        if (shift)    return {a, 1'b0};
        else if (sub) return {1'b0, a} - {1'b0, b};
        else          return {1'b0, a} + {1'b0, b};
    endfunction

    // Adder latency in cycles from start to done depends on the low bits of A.
    function automatic int lat_of(input logic [W-1:0] a);
        return 2 + int'(a[1:0]);
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Next requester to serve: first pending one after the last served, wrapping.
    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural adder driven on the falling edge; also injects spurious done pulses.
    initial begin : adder_model
        int           rem;
        int           spur_ack;
        logic [W-1:0] la;
        logic [W-1:0] lb;
        logic         lsub;
        logic         lshift;
        rem          = 0;
        spur_ack     = 0;
        la           = '0;
        lb           = '0;
        lsub         = 1'b0;
        lshift       = 1'b0;
        adder_done   = 1'b0;
        adder_result = '0;
        forever begin
            @(negedge clk);
            adder_done = 1'b0;
            if (reset) begin
                rem = 0;
            end else begin
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        adder_done   = 1'b1;
                        adder_result = op_result(la, lb, lsub, lshift);
                    end
                end
                if (adder_start && !adder_hang) begin
                    la     = adder_a;
                    lb     = adder_b;
                    lsub   = adder_sub;
                    lshift = adder_shift;
                    rem    = lat_of(adder_a);
                end
                if (spur_req != spur_ack) begin
                    spur_ack++;
                    adder_done   = 1'b1;
                    adder_result = {1'b1, $urandom, $urandom};
                end
            end
        end
    end

    // Scoreboard monitor: predicts the winner when the arbiter is free and a request
    // is pending, then checks grant/busy/start every cycle and the done response.
    initial begin : monitor
        bit   m_busy;
        bit   m_err;
        bit   rst_d;
        int   m_last;
        int   m_pred;
        int   m_pred_cyc;
        int   m_done_cyc;
        int   cyc;
        exp_t m_cur;
        m_busy     = 0;
        m_err      = 0;
        rst_d      = 1;
        m_last     = N - 1;
        m_pred     = 0;
        m_pred_cyc = 0;
        m_done_cyc = 0;
        cyc        = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                m_busy = 0;
                m_err  = 0;
                m_last = N - 1;
                rst_d  = 1;
                for (int i = 0; i < N; i++) exp_q[i].delete();
            end else begin
                if (rst_d) begin
                    chk("rst_grant", grant, '0);
                    chk("rst_done", done, '0);
                    chk("rst_busy", busy, '0);
                    chk("rst_timeout_err", timeout_err, '0);
                    chk("rst_result", result, '0);
                    chk("rst_adder_a", adder_a, '0);
                    chk("rst_adder_b", adder_b, '0);
                    chk("rst_flags", {adder_start, adder_sub, adder_shift}, '0);
                    rst_d = 0;
                end
                chk("grant", grant, m_busy ? onehot(m_pred) : '0);
                chk("busy", busy, m_busy);
                chk("start", adder_start, m_busy && (cyc == m_pred_cyc + 1));
                if (m_busy && (cyc == m_pred_cyc + 1)) begin
                    chk("latch_a", adder_a, m_cur.a);
                    chk("latch_b", adder_b, m_cur.b);
                    chk("latch_mode", {adder_sub, adder_shift}, {m_cur.sub, m_cur.shift});
                end
                if (done != '0) begin
                    chk("done_who", done, m_busy ? onehot(m_pred) : '0);
                    if (m_busy) begin
                        if (m_cur.hang) m_err = 1;
                        chk("done_cycle", cyc, m_done_cyc);
                        chk("result", result, m_cur.hang ? '0 : m_cur.res);
                        chk("timeout_err", timeout_err, m_err);
                        chk("hold_a", adder_a, m_cur.a);
                        $display("op req=%0d a=%0h b=%0h sub=%0b shift=%0b result=%0h err=%0b cyc=%0d",
                                 m_pred, m_cur.a, m_cur.b, m_cur.sub, m_cur.shift, result, timeout_err, cyc);
                        void'(exp_q[m_pred].pop_front());
                        m_last = m_pred;
                        m_busy = 0;
                    end
                end else if (m_busy && cyc > m_done_cyc) begin
                    chk("done_missing", done, onehot(m_pred));
                    void'(exp_q[m_pred].pop_front());
                    m_last = m_pred;
                    m_busy = 0;
                end else if (!m_busy && req != '0) begin
                    m_pred = rr_next(req, m_last);
                    if (exp_q[m_pred].size() > 0) begin
                        m_cur      = exp_q[m_pred][0];
                        m_pred_cyc = cyc;
                        m_done_cyc = cyc + (m_cur.hang ? 3 + TO : 2 + m_cur.lat);
                        m_busy     = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic shift, input bit hang);
        exp_t e;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[i]      = sub;
        req_shift[i]    = shift;
        e.a     = a;
        e.b     = b;
        e.sub   = sub;
        e.shift = shift;
        e.res   = op_result(a, b, sub, shift);
        e.lat   = lat_of(a);
        e.hang  = hang;
        exp_q[i].push_back(e);
        req[i] = 1'b1;
    endtask

    task automatic issue_rand(input int i);
        issue(i, {$urandom, $urandom}, {$urandom, $urandom},
              1'(($urandom % 2) == 1), 1'(($urandom % 4) == 0), 1'b0);
    endtask

    // Requesters drop req in their done cycle; those with reps left re-request next cycle.
    // late_mask requesters raise a fresh request at iteration late_at if they are idle.
    task automatic run_until_idle(input int budget, input logic [N-1:0] late_mask, input int late_at);
        int n;
        bit re [N];
        bit any_re;
        n = 0;
        for (int i = 0; i < N; i++) re[i] = 0;
        any_re = 0;
        while ((req != '0 || any_re || n <= late_at) && n < budget) begin
            tick();
            n++;
            for (int i = 0; i < N; i++) begin
                if (re[i]) begin
                    issue_rand(i);
                    re[i] = 0;
                    reps[i]--;
                end
            end
            if (n == late_at) begin
                for (int i = 0; i < N; i++) begin
                    if (late_mask[i] && !req[i]) issue_rand(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (done[i] && req[i]) begin
                    req[i] = 1'b0;
                    if (reps[i] > 0) re[i] = 1;
                end
            end
            any_re = 0;
            for (int i = 0; i < N; i++) any_re |= re[i];
        end
        chk("serve_budget", (n < budget), 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset     = 1'b1;
        req       = '0;
        req_sub   = '0;
        req_shift = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) reps[i] = 0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single op: 10 - 3 on requester 0, adder latency 4.
        issue(0, 64'd10, 64'd3, 1'b1, 1'b0, 1'b0);
        run_until_idle(100, '0, 0);
        tick();

        // Simultaneous requests right after reset: requester 0 first, then 1.
        do_reset();
        issue(0, 64'd5, 64'd6, 1'b0, 1'b0, 1'b0);
        issue(1, 64'd20, 64'd1, 1'b1, 1'b0, 1'b0);
        run_until_idle(100, '0, 0);
        tick();

        // Fairness: two requesters hold for 6 ops each, then all three for 4 each.
        reps[0] = 5;
        reps[1] = 5;
        issue_rand(0);
        issue_rand(1);
        run_until_idle(500, '0, 0);
        for (int i = 0; i < N; i++) begin
            reps[i] = 3;
            issue_rand(i);
        end
        run_until_idle(500, '0, 0);
        tick();

        // Randomized batches with occasional late arrivals during an op.
        for (int it = 0; it < 30; it++) begin
            logic [N-1:0] mask;
            logic [N-1:0] late;
            mask = N'($urandom_range(1, (1 << N) - 1));
            late = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                reps[i] = $urandom_range(0, 2);
                if (mask[i]) issue_rand(i);
            end
            run_until_idle(1000, late, $urandom_range(1, 8));
            repeat ($urandom_range(0, 3)) tick();
        end

        // Timeout: the adder never answers; result forced to 0, error sticks afterwards.
        adder_hang = 1;
        issue(2, 64'd100, 64'd1, 1'b0, 1'b0, 1'b1);
        run_until_idle(200, '0, 0);
        adder_hang = 0;
        issue(0, 64'd7, 64'd9, 1'b0, 1'b0, 1'b0);
        run_until_idle(100, '0, 0);
        issue(1, 64'd3, 64'd7, 1'b1, 1'b0, 1'b0);
        run_until_idle(100, '0, 0);
        tick();

        // Spurious adder_done in IDLE and in ISSUE must be ignored.
        spur_req++;
        tick();
        tick();
        tick();
        issue(1, 64'd33, 64'd44, 1'b0, 1'b0, 1'b0);
        tick();
        spur_req++;
        run_until_idle(100, '0, 0);
        tick();

        // Reset during the second WAIT cycle abandons the op silently.
        adder_hang = 1;
        issue(0, 64'd1, 64'd2, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        reset = 1'b1;
        req   = '0;
        tick();
        reset      = 1'b0;
        adder_hang = 0;
        tick();
        issue(1, 64'd40, 64'd2, 1'b0, 1'b1, 1'b0);
        run_until_idle(100, '0, 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
